// File: rtl/stage_param_loader.sv
// stage_param_loader: fetches one stage's parameter words from the cascade ROM
// into a flat buffer and hands it to the stage classifier under valid/ack.
// Each ROM return is tagged with its word index by a fixed-latency pipeline,
// so the loader never stalls and never needs to count returns separately.
module stage_param_loader #(
    parameter int DATA_WIDTH_8             = 8,
    parameter int NUM_PARAM_PER_CLASSIFIER = 18,
    parameter int NUM_STAGE_THRESHOLD      = 1,
    parameter int NUM_CLASSIFIERS          = 10,
    parameter int ROM_ADDR_WIDTH           = 12,
    parameter int STAGE_STRIDE             = 181,
    parameter int ROM_LATENCY              = 1,
    localparam int NUM_WORDS = NUM_CLASSIFIERS*NUM_PARAM_PER_CLASSIFIER + NUM_STAGE_THRESHOLD
) (
    input  logic                              clk_fpga,
    input  logic                              reset,
    input  logic                              i_start,
    input  logic [7:0]                        i_stage_index,
    output logic [ROM_ADDR_WIDTH-1:0]         o_rom_addr,
    output logic                              o_rom_rden,
    input  logic [DATA_WIDTH_8-1:0]           i_rom_data,
    output logic [NUM_WORDS*DATA_WIDTH_8-1:0] o_stage_params,
    output logic                              o_param_valid,
    input  logic                              i_param_ack,
    output logic                              o_busy
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_VALID} state_t;

    state_t                                   r_state;
    state_t                                   w_next;
    logic                                     r_rden;
    logic [ROM_ADDR_WIDTH-1:0]                r_addr;
    logic [IDX_W-1:0]                         r_idx;
    logic [ROM_LATENCY:1]                     r_pipe_vld;
    logic [ROM_LATENCY:1][IDX_W-1:0]          r_pipe_idx;
    logic [NUM_WORDS-1:0][DATA_WIDTH_8-1:0]   r_params;
    logic                                     w_accept;
    logic                                     w_last_cap;
    logic [ROM_ADDR_WIDTH-1:0]                w_base;

    // Base address wraps modulo the ROM size; computed at 32 bits then truncated.
    assign w_base = ROM_ADDR_WIDTH'(32'(i_stage_index) * 32'(STAGE_STRIDE));

    // A start is honoured from IDLE, or from VALID only when the buffer is acked in the same cycle.
    assign w_accept = i_start && ((r_state == S_IDLE) ||
                                  (r_state == S_VALID && i_param_ack));

    // The return at the tail of the tag pipeline carrying the final index completes the buffer.
    assign w_last_cap = r_pipe_vld[ROM_LATENCY] && (r_pipe_idx[ROM_LATENCY] == LAST_IDX);

    assign o_rom_rden     = r_rden;
    assign o_rom_addr     = r_addr;
    assign o_stage_params = r_params;

    // State register.
    always_ff @(posedge clk_fpga) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_FETCH;
            S_FETCH: if (r_idx == LAST_IDX) w_next = S_DRAIN;
            S_DRAIN: if (w_last_cap) w_next = S_VALID;
            S_VALID: if (i_param_ack) w_next = i_start ? S_FETCH : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        o_busy        = (r_state == S_FETCH) || (r_state == S_DRAIN);
        o_param_valid = (r_state == S_VALID);
    end

    // Address issue, return tagging and in-place buffer capture.
    always_ff @(posedge clk_fpga) begin
        if (reset) begin
            r_rden     <= 1'b0;
            r_addr     <= '0;
            r_idx      <= '0;
            r_pipe_vld <= '0;
            r_pipe_idx <= '0;
            r_params   <= '0;
        end else begin
            r_pipe_vld[1] <= r_rden;
            r_pipe_idx[1] <= r_idx;
            for (int j = 2; j <= ROM_LATENCY; j++) begin
                r_pipe_vld[j] <= r_pipe_vld[j-1];
                r_pipe_idx[j] <= r_pipe_idx[j-1];
            end
            if (r_pipe_vld[ROM_LATENCY])
                r_params[r_pipe_idx[ROM_LATENCY]] <= i_rom_data;
            if (w_accept) begin
                r_rden <= 1'b1;
                r_addr <= w_base;
                r_idx  <= '0;
            end else if (r_rden) begin
                if (r_idx == LAST_IDX) begin
                    r_rden <= 1'b0;
                end else begin
                    r_idx  <= r_idx + 1'b1;
                    r_addr <= r_addr + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_stage_param_loader.sv
// Bench for stage_param_loader: two instances (ROM latency 1 and 3) each fed
// by a behavioural ROM; loads are checked cycle by cycle against addresses and
// buffer contents derived directly from stage*stride and the ROM image.
module tb_stage_param_loader;

    localparam int NW  = 181;
    localparam int AW  = 12;
    localparam int BW  = NW*8;

    logic            clk = 1'b0;
    logic            rst;
    logic            st   [2];
    logic [7:0]      si   [2];
    logic            ak   [2];
    logic [AW-1:0]   addr [2];
    logic            rden [2];
    logic [7:0]      rdat [2];
    logic [BW-1:0]   prm  [2];
    logic            pv   [2];
    logic            bz   [2];

    logic [7:0]      rom  [4096];
    logic [7:0]      q1;
    logic [7:0]      q3   [3];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    stage_param_loader #(.ROM_LATENCY(1)) u_l1 (
        .clk_fpga(clk), .reset(rst), .i_start(st[0]), .i_stage_index(si[0]),
        .o_rom_addr(addr[0]), .o_rom_rden(rden[0]), .i_rom_data(rdat[0]),
        .o_stage_params(prm[0]), .o_param_valid(pv[0]), .i_param_ack(ak[0]),
        .o_busy(bz[0]));

    stage_param_loader #(.ROM_LATENCY(3)) u_l3 (
        .clk_fpga(clk), .reset(rst), .i_start(st[1]), .i_stage_index(si[1]),
        .o_rom_addr(addr[1]), .o_rom_rden(rden[1]), .i_rom_data(rdat[1]),
        .o_stage_params(prm[1]), .o_param_valid(pv[1]), .i_param_ack(ak[1]),
        .o_busy(bz[1]));

    // Behavioural ROMs: unread cycles return 8'hEE so a misaligned capture shows up.
    always @(posedge clk) begin
        q1    <= rden[0] ? rom[addr[0]] : 8'hEE;
        q3[0] <= rden[1] ? rom[addr[1]] : 8'hEE;
        q3[1] <= q3[0];
        q3[2] <= q3[1];
    end
    assign rdat[0] = q1;
    assign rdat[1] = q3[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int base_of(input int stage);
        return (stage * 181) % 4096;
    endfunction

    // Compare every buffer word of instance d with the ROM contents for the given stage.
    task automatic chk_buf(input int d, input int stage, input string tag);
        int b;
        b = base_of(stage);
        for (int k = 0; k < NW; k++)
            chk($sformatf("%s_d%0d_w%0d", tag, d, k), 32'(prm[d][k*8 +: 8]), 32'(rom[(b+k)%4096]));
    endtask

    // One full load, checked cycle by cycle. Caller is #1 into a cycle with
    // instance d idle (or valid, when b2b acks in the start cycle).
    task automatic do_load(input int d, input int stage, input bit b2b, input bit inject, input int lat);
        int b;
        b = base_of(stage);
        si[d] = 8'(stage);
        st[d] = 1'b1;
        if (b2b) ak[d] = 1'b1;
        tick();
        st[d] = 1'b0;
        ak[d] = 1'b0;
        for (int n = 1; n <= 182 + lat; n++) begin
            if (n <= 181) begin
                chk($sformatf("rden_d%0d_c%0d", d, n), 32'(rden[d]), 1);
                chk($sformatf("addr_d%0d_c%0d", d, n), 32'(addr[d]), 32'((b + n - 1) % 4096));
            end else begin
                chk($sformatf("rden_d%0d_c%0d", d, n), 32'(rden[d]), 0);
            end
            chk($sformatf("valid_d%0d_c%0d", d, n), 32'(pv[d]), 32'(n == 182 + lat));
            chk($sformatf("busy_d%0d_c%0d", d, n), 32'(bz[d]), 32'(n <= 181 + lat));
            if (inject && (n == 50 || n == 182)) begin
                st[d] = 1'b1;
                si[d] = 8'(stage) ^ 8'h5A;
            end else begin
                st[d] = 1'b0;
            end
            if (n < 182 + lat) tick();
        end
        st[d] = 1'b0;
        chk_buf(d, stage, "load");
    endtask

    task automatic do_ack(input int d);
        ak[d] = 1'b1;
        tick();
        ak[d] = 1'b0;
        chk($sformatf("ackvalid_d%0d", d), 32'(pv[d]), 0);
        chk($sformatf("ackbusy_d%0d", d), 32'(bz[d]), 0);
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            st[d] = 1'b0; si[d] = '0; ak[d] = 1'b0;
        end
        for (int a = 0; a < 4096; a++) rom[a] = 8'(a);
        repeat (3) tick();

        // Reset state of both instances.
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_addr_d%0d", d), 32'(addr[d]), 0);
            chk($sformatf("rst_rden_d%0d", d), 32'(rden[d]), 0);
            chk($sformatf("rst_valid_d%0d", d), 32'(pv[d]), 0);
            chk($sformatf("rst_busy_d%0d", d), 32'(bz[d]), 0);
            for (int k = 0; k < NW; k++)
                chk($sformatf("rst_w%0d_d%0d", k, d), 32'(prm[d][k*8 +: 8]), 0);
        end
        rst = 1'b0;
        tick();

        // Stage 0 with an identity-ish ROM image.
        do_load(0, 0, 1'b0, 1'b0, 1);
        chk("s0_w180", 32'(prm[0][180*8 +: 8]), 32'h0B4);
        do_ack(0);

        // Random ROM image from here on.
        for (int a = 0; a < 4096; a++) rom[a] = 8'($urandom);

        // Stage 3 with ignored starts during FETCH and DRAIN.
        do_load(0, 3, 1'b0, 1'b1, 1);
        chk("s3_w0", 32'(prm[0][7:0]), 32'(rom[543]));
        chk("s3_w180", 32'(prm[0][180*8 +: 8]), 32'(rom[723]));

        // Held in VALID with ack low; a start without ack must be ignored.
        for (int c = 0; c < 50; c++) begin
            if (c == 10) begin st[0] = 1'b1; si[0] = 8'd9; end
            else st[0] = 1'b0;
            tick();
            chk($sformatf("hold_valid_c%0d", c), 32'(pv[0]), 1);
            chk($sformatf("hold_rden_c%0d", c), 32'(rden[0]), 0);
        end
        st[0] = 1'b0;
        chk_buf(0, 3, "hold");

        // Back-to-back: start stage 1 with ack in the same cycle.
        do_load(0, 1, 1'b1, 1'b0, 1);
        do_ack(0);

        // Latency-3 instance, with ignored starts.
        do_load(1, 7, 1'b0, 1'b1, 3);
        do_ack(1);
        do_load(1, int'($urandom_range(0, 255)), 1'b0, 1'b0, 3);
        do_ack(1);

        // Reset in cycle 90 of a fetch.
        si[0] = 8'd5;
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        repeat (89) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rden", 32'(rden[0]), 0);
        chk("mid_busy", 32'(bz[0]), 0);
        chk("mid_valid", 32'(pv[0]), 0);
        for (int k = 0; k < NW; k++)
            chk($sformatf("mid_w%0d", k), 32'(prm[0][k*8 +: 8]), 0);
        repeat (4) tick();

        // Address wrap at stage 255 (base 1099), then a few random loads.
        do_load(0, 255, 1'b0, 1'b0, 1);
        do_ack(0);
        for (int r = 0; r < 3; r++) begin
            do_load(0, int'($urandom_range(0, 255)), 1'b0, 1'b0, 1);
            do_ack(0);
            do_load(1, int'($urandom_range(0, 255)), 1'b0, 1'b0, 3);
            do_ack(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
